aes_decrypt_round_ctrl: RTL and testbench

- Iterative AES-128 decryption sequencer. Accepts one 128-bit ciphertext block over a valid/ready handshake.
- Performs the initial AddRoundKey internally, then drives an external shared round datapath for nine NORMAL rounds and one FINAL round.
- Fetches round keys 10..0 from a synchronous expanded-key RAM filled by the key-expansion block.
- Returns the plaintext over a valid/ready handshake. Sits between the host stream interface and the round datapath / key RAM.

---
 rtl/aes_decrypt_round_ctrl.sv | 134 +++++++++++++
 tb/tb_aes_decrypt_round_ctrl.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_round_ctrl.sv
// rtl/aes_decrypt_round_ctrl.sv - iterative AES-128 decryption sequencer
// Owns the state register and key fetch order; the round transform lives in an external datapath.
module aes_decrypt_round_ctrl #(
  parameter int DATA_W  = 128,
  parameter int ROUNDS  = 10,
  parameter int KADDR_W = 4
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               KEY_READY,
  input  logic               IN_VALID,
  output logic               IN_READY,
  input  logic [DATA_W-1:0]  IN_DATA,
  output logic               OUT_VALID,
  input  logic               OUT_READY,
  output logic [DATA_W-1:0]  OUT_DATA,
  output logic               KEY_EN,
  output logic [KADDR_W-1:0] KEY_ADDR,
  input  logic [DATA_W-1:0]  KEY_DATA,
  output logic [1:0]         DP_MODE,
  output logic [DATA_W-1:0]  DP_DATA,
  output logic [DATA_W-1:0]  DP_KEY,
  input  logic [DATA_W-1:0]  DP_RESULT,
  output logic               BUSY
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_INIT,
    S_ROUND,
    S_FINAL,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic [DATA_W-1:0]  blk_q, blk_d;
  logic [3:0]         rnd_q, rnd_d;
  logic [KADDR_W-1:0] key_addr_q, key_addr_d;
  logic               key_en_q, key_en_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [1:0]         dp_mode;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state_q     <= S_IDLE;
      blk_q       <= '0;
      rnd_q       <= '0;
      key_addr_q  <= '0;
      key_en_q    <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      rnd_q       <= rnd_d;
      key_addr_q  <= key_addr_d;
      key_en_q    <= key_en_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
    end
  end

  // Key RAM has one cycle of read latency, so KEY_ADDR always runs one key ahead of use.
  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    rnd_d       = rnd_q;
    key_addr_d  = key_addr_q;
    key_en_d    = key_en_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    dp_mode     = 2'd0;
    case (state_q)
      S_IDLE: begin
        if (IN_VALID && KEY_READY) begin
          blk_d      = IN_DATA;
          key_addr_d = KADDR_W'(ROUNDS);
          key_en_d   = 1'b1;
          state_d    = S_LOAD;
        end
      end
      S_LOAD: begin
        key_addr_d = KADDR_W'(ROUNDS - 1);
        state_d    = S_INIT;
      end
      S_INIT: begin
        blk_d      = blk_q ^ KEY_DATA;
        key_addr_d = KADDR_W'(ROUNDS - 2);
        rnd_d      = 4'(ROUNDS - 1);
        state_d    = S_ROUND;
      end
      S_ROUND: begin
        dp_mode = 2'd1;
        blk_d   = DP_RESULT;
        if (rnd_q >= 4'd2) begin
          key_addr_d = KADDR_W'(rnd_q - 4'd2);
        end
        rnd_d = rnd_q - 4'd1;
        if (rnd_q == 4'd1) begin
          state_d = S_FINAL;
        end
      end
      S_FINAL: begin
        dp_mode     = 2'd2;
        out_data_d  = DP_RESULT;
        out_valid_d = 1'b1;
        key_en_d    = 1'b0;
        state_d     = S_DONE;
      end
      S_DONE: begin
        if (OUT_READY) begin
          out_valid_d = 1'b0;
          state_d     = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign IN_READY  = (state_q == S_IDLE) && KEY_READY;
  assign OUT_VALID = out_valid_q;
  assign OUT_DATA  = out_data_q;
  assign KEY_EN    = key_en_q;
  assign KEY_ADDR  = key_addr_q;
  assign DP_MODE   = dp_mode;
  assign DP_DATA   = blk_q;
  assign DP_KEY    = KEY_DATA;
  assign BUSY      = (state_q != S_IDLE);

endmodule

// File: tb/tb_aes_decrypt_round_ctrl.sv
// tb/tb_aes_decrypt_round_ctrl.sv - self-checking bench for aes_decrypt_round_ctrl
// Bench supplies the key RAM and a golden inverse-round datapath built from GF(2^8) arithmetic.
module tb_aes_decrypt_round_ctrl;

  logic         clk;
  logic         rst_n;
  logic         key_ready;
  logic         in_valid;
  logic         in_ready;
  logic [127:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic [127:0] out_data;
  logic         key_en;
  logic [3:0]   key_addr;
  logic [127:0] key_data;
  logic [1:0]   dp_mode;
  logic [127:0] dp_data;
  logic [127:0] dp_key;
  logic [127:0] dp_result;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0]   sbox     [256];
  logic [7:0]   inv_sbox [256];
  logic [127:0] kram     [16];

  aes_decrypt_round_ctrl dut (
    .CLK       (clk),
    .RST_N     (rst_n),
    .KEY_READY (key_ready),
    .IN_VALID  (in_valid),
    .IN_READY  (in_ready),
    .IN_DATA   (in_data),
    .OUT_VALID (out_valid),
    .OUT_READY (out_ready),
    .OUT_DATA  (out_data),
    .KEY_EN    (key_en),
    .KEY_ADDR  (key_addr),
    .KEY_DATA  (key_data),
    .DP_MODE   (dp_mode),
    .DP_DATA   (dp_data),
    .DP_KEY    (dp_key),
    .DP_RESULT (dp_result),
    .BUSY      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (key_en) key_data <= kram[key_addr];
  end

  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, x, y;
    p = 8'h00; x = a; y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = xtime(x);
      y = y >> 1;
    end
    return p;
  endfunction

  task automatic init_tables();
    logic [7:0] inv, s, r;
    for (int x = 0; x < 256; x++) begin
      inv = 8'h00;
      for (int y = 1; y < 256; y++) begin
        if (gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      end
      s = inv; r = inv;
      for (int k = 0; k < 4; k++) begin
        r = {r[6:0], r[7]};
        s = s ^ r;
      end
      s = s ^ 8'h63;
      sbox[x] = s;
      inv_sbox[s] = 8'(x);
    end
  endtask

  function automatic logic [127:0] round_key(input logic [127:0] key, input int r);
    logic [31:0] w [44];
    logic [31:0] t;
    logic [7:0]  rc;
    w[0] = key[127:96]; w[1] = key[95:64]; w[2] = key[63:32]; w[3] = key[31:0];
    rc = 8'h01;
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox[t[31:24]], sbox[t[23:16]], sbox[t[15:8]], sbox[t[7:0]]};
        t[31:24] = t[31:24] ^ rc;
        rc = xtime(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    return {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
  endfunction

  // mode 1: InvShiftRows, InvSubBytes, AddRoundKey, InvMixColumns; mode 2 skips the mix.
  function automatic logic [127:0] inv_round(input logic [1:0] mode, input logic [127:0] s,
                                             input logic [127:0] k);
    logic [7:0]   a [16];
    logic [7:0]   t [16];
    logic [127:0] o;
    logic [7:0]   c0, c1, c2, c3;
    if (mode != 2'd1 && mode != 2'd2) return '0;
    for (int i = 0; i < 16; i++) a[i] = s[127-8*i -: 8];
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        t[c*4+r] = inv_sbox[a[((c - r + 4) % 4)*4 + r]];
    for (int i = 0; i < 16; i++) o[127-8*i -: 8] = t[i];
    o = o ^ k;
    if (mode == 2'd1) begin
      for (int c = 0; c < 4; c++) begin
        c0 = o[127-32*c -: 8]; c1 = o[119-32*c -: 8];
        c2 = o[111-32*c -: 8]; c3 = o[103-32*c -: 8];
        o[127-32*c -: 8] = gmul(c0,8'h0e) ^ gmul(c1,8'h0b) ^ gmul(c2,8'h0d) ^ gmul(c3,8'h09);
        o[119-32*c -: 8] = gmul(c0,8'h09) ^ gmul(c1,8'h0e) ^ gmul(c2,8'h0b) ^ gmul(c3,8'h0d);
        o[111-32*c -: 8] = gmul(c0,8'h0d) ^ gmul(c1,8'h09) ^ gmul(c2,8'h0e) ^ gmul(c3,8'h0b);
        o[103-32*c -: 8] = gmul(c0,8'h0b) ^ gmul(c1,8'h0d) ^ gmul(c2,8'h09) ^ gmul(c3,8'h0e);
      end
    end
    return o;
  endfunction

  assign dp_result = inv_round(dp_mode, dp_data, dp_key);

  function automatic logic [127:0] aes_dec(input logic [127:0] ct, input logic [127:0] key);
    logic [127:0] s;
    s = ct ^ round_key(key, 10);
    for (int r = 9; r >= 1; r--) s = inv_round(2'd1, s, round_key(key, r));
    return inv_round(2'd2, s, round_key(key, 0));
  endfunction

  task automatic load_key(input logic [127:0] key);
    for (int r = 0; r <= 10; r++) kram[r] = round_key(key, r);
  endtask

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Returns one ns into cycle T+1, where T is the accept cycle.
  task automatic accept(input logic [127:0] ct);
    int w;
    w = 0;
    in_data = ct;
    in_valid = 1'b1;
    #1;
    while (!in_ready && w < 50) begin
      tick(); #1; w++;
    end
    check("accept_wait", 128'(w < 50), 128'(1));
    tick();
    in_valid = 1'b0;
    in_data = ~ct;
  endtask

  task automatic do_block(input string name, input logic [127:0] ct, input logic [127:0] exp,
                          input int hold);
    int n;
    accept(ct);
    n = 1;
    while (!out_valid && n < 40) begin
      tick(); n++;
    end
    check({name, "_latency"}, 128'(n), 128'(13));
    check({name, "_data"}, out_data, exp);
    for (int h = 0; h < hold; h++) begin
      tick();
      check({name, "_hold_valid"}, 128'(out_valid), 128'(1));
      check({name, "_hold_data"}, out_data, exp);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check({name, "_valid_drop"}, 128'(out_valid), 128'(0));
    check({name, "_idle"}, 128'(busy), 128'(0));
  endtask

  typedef struct {
    logic [127:0] key;
    logic [127:0] ct;
    logic [127:0] pt;
  } vec_t;

  localparam logic [127:0] C1_KEY = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1_CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] C1_PT  = 128'h00112233445566778899aabbccddeeff;

  initial begin
    vec_t         vecs [3];
    logic [127:0] k, c, e;
    int           mode1_n, mode2_n, na, no, seen;
    int           acc_t [2];
    logic [127:0] out_d [2];

    vecs[0] = '{C1_KEY, C1_CT, C1_PT};
    vecs[1] = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h3925841d02dc09fbdc118597196a0b32,
                128'h3243f6a8885a308d313198a2e0370734};
    vecs[2] = '{128'h0, 128'h66e94bd4ef8a2c3b884cfa59ca342b2e, 128'h0};

    rst_n = 1'b0; key_ready = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    init_tables();
    for (int r = 0; r < 16; r++) kram[r] = '0;
    load_key(C1_KEY);
    repeat (3) tick();
    check("rst_out_valid", 128'(out_valid), 128'(0));
    check("rst_out_data", out_data, 128'(0));
    check("rst_key_en", 128'(key_en), 128'(0));
    check("rst_key_addr", 128'(key_addr), 128'(0));
    check("rst_dp_mode", 128'(dp_mode), 128'(0));
    check("rst_busy", 128'(busy), 128'(0));
    check("rst_in_ready", 128'(in_ready), 128'(0));
    rst_n = 1'b1;
    tick();

    // KEY_READY gating, then the detailed cycle walk of one block
    in_valid = 1'b1; in_data = C1_CT;
    for (int i = 0; i < 3; i++) begin
      check("gate_in_ready", 128'(in_ready), 128'(0));
      check("gate_busy", 128'(busy), 128'(0));
      tick();
    end
    key_ready = 1'b1;
    #1;
    check("gate_accept_same_cycle", 128'(in_ready), 128'(1));
    tick();
    in_valid = 1'b0; in_data = ~C1_CT;
    mode1_n = 0; mode2_n = 0;
    for (int t = 1; t <= 12; t++) begin
      check($sformatf("seq_key_addr_t%0d", t), 128'(key_addr), 128'(t <= 11 ? 11 - t : 0));
      check($sformatf("seq_key_en_t%0d", t), 128'(key_en), 128'(1));
      check($sformatf("seq_busy_t%0d", t), 128'(busy), 128'(1));
      check($sformatf("seq_dp_mode_t%0d", t), 128'(dp_mode),
            128'((t >= 3 && t <= 11) ? 1 : (t == 12 ? 2 : 0)));
      if (dp_mode == 2'd1) mode1_n++;
      if (dp_mode == 2'd2) mode2_n++;
      if (t == 3) check("seq_first_round_dp_data", dp_data,
                        128'h7ad5fda789ef4e272bca100b3d9ff59f);
      tick();
    end
    check("seq_mode1_cycles", 128'(mode1_n), 128'(9));
    check("seq_mode2_cycles", 128'(mode2_n), 128'(1));
    check("seq_out_valid_t13", 128'(out_valid), 128'(1));
    check("seq_out_data", out_data, C1_PT);
    check("seq_key_en_t13", 128'(key_en), 128'(0));
    check("seq_dp_mode_t13", 128'(dp_mode), 128'(0));

    // Output backpressure with a competing ciphertext offered
    in_valid = 1'b1; in_data = {$urandom, $urandom, $urandom, $urandom};
    for (int i = 0; i < 20; i++) begin
      check("bp_out_valid", 128'(out_valid), 128'(1));
      check("bp_out_data", out_data, C1_PT);
      check("bp_in_ready", 128'(in_ready), 128'(0));
      tick();
    end
    in_valid = 1'b0; out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", 128'(out_valid), 128'(0));
    check("bp_release_busy", 128'(busy), 128'(0));
    check("bp_release_in_ready", 128'(in_ready), 128'(1));

    // Table of known-answer vectors
    for (int i = 0; i < 3; i++) begin
      load_key(vecs[i].key);
      do_block($sformatf("kat%0d", i), vecs[i].ct, vecs[i].pt, i);
    end

    // Back-to-back with both handshakes held high
    load_key(C1_KEY);
    na = 0; no = 0; acc_t[0] = 0; acc_t[1] = 0; out_d[0] = '0; out_d[1] = '0;
    in_valid = 1'b1; in_data = C1_CT; out_ready = 1'b1;
    for (int cyc = 0; cyc < 60 && no < 2; cyc++) begin
      if (in_valid && in_ready && na < 2) begin acc_t[na] = cyc; na++; end
      if (out_valid && no < 2) begin out_d[no] = out_data; no++; end
      tick();
      if (na == 2) in_valid = 1'b0;
    end
    out_ready = 1'b0; in_valid = 1'b0;
    check("b2b_accepts", 128'(na), 128'(2));
    check("b2b_outputs", 128'(no), 128'(2));
    check("b2b_spacing", 128'(acc_t[1] - acc_t[0]), 128'(14));
    check("b2b_data0", out_d[0], C1_PT);
    check("b2b_data1", out_d[1], C1_PT);
    tick();

    // Reset at T+6 discards the block
    accept(C1_CT);
    repeat (5) tick();
    check("mid_busy_before_reset", 128'(busy), 128'(1));
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mid_rst_busy", 128'(busy), 128'(0));
    check("mid_rst_out_valid", 128'(out_valid), 128'(0));
    check("mid_rst_out_data", out_data, 128'(0));
    check("mid_rst_key_en", 128'(key_en), 128'(0));
    check("mid_rst_key_addr", 128'(key_addr), 128'(0));
    check("mid_rst_dp_mode", 128'(dp_mode), 128'(0));
    seen = 0;
    for (int i = 0; i < 20; i++) begin
      if (out_valid) seen++;
      tick();
    end
    check("mid_no_output", 128'(seen), 128'(0));
    do_block("post_reset", C1_CT, C1_PT, 0);

    // Random keys and blocks against the reference decryptor
    for (int i = 0; i < 6; i++) begin
      k = {$urandom, $urandom, $urandom, $urandom};
      c = {$urandom, $urandom, $urandom, $urandom};
      e = aes_dec(c, k);
      load_key(k);
      repeat ($urandom_range(0, 3)) tick();
      do_block($sformatf("rand%0d", i), c, e, $urandom_range(0, 4));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
